// File: rtl/cascaded_hpf_pkg.sv
// Shared types and helpers for the cascaded leaky-differentiator high-pass filter.
// Stage arithmetic carries GUARD_BITS extra bits so the unclamped sum never wraps.
package cascaded_hpf_pkg;

  localparam int GUARD_BITS = 2;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_e;

  // Clamp a wide signed value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] value,
                                               input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/cascaded_k_high_pass_filter_if.sv
// Sample, configuration and status bundle of the cascaded high-pass filter.
// The slave side is the filter; the master side is whatever feeds and reads it.
interface cascaded_k_high_pass_filter_if #(
  parameter int WIDTH     = 16,
  parameter int MAX_ORDER = 4,
  parameter int KW        = 4
);
  localparam int OW = $clog2(MAX_ORDER + 1);

  logic                    enable;
  logic signed [WIDTH-1:0] x;
  logic [OW-1:0]           cfg_order;
  logic [KW-1:0]           cfg_k;
  logic                    cfg_load;
  logic signed [WIDTH-1:0] y;
  logic                    y_valid;
  logic                    settling;
  logic                    sat;

  modport master (
    output enable, x, cfg_order, cfg_k, cfg_load,
    input  y, y_valid, settling, sat
  );

  modport slave (
    input  enable, x, cfg_order, cfg_k, cfg_load,
    output y, y_valid, settling, sat
  );
endinterface

// File: rtl/k_hpf_stage.sv
// One first-order leaky-differentiator stage: y <= sat(x - xd + y - (y >>> k)).
// When inactive the stage is a plain register so total latency never depends on order.
module k_hpf_stage
  import cascaded_hpf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [KW-1:0]           k,
  input  logic signed [WIDTH-1:0] x_i,
  output logic signed [WIDTH-1:0] y_o,
  output logic                    sat_o
);
  localparam int SW = WIDTH + GUARD_BITS;

  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] xd_q, xd_d;
  logic signed [SW-1:0]    x_e, xd_e, y_e, s;
  logic signed [63:0]      s_sat;
  logic [KW-1:0]           k_eff;

  always_comb begin
    k_eff = (k == '0) ? KW'(1) : k;
    x_e   = SW'(x_i);
    xd_e  = SW'(xd_q);
    y_e   = SW'(y_q);
    s     = x_e - xd_e + y_e - (y_e >>> k_eff);
    s_sat = sat_w(64'(s), WIDTH);
    y_d   = y_q;
    xd_d  = xd_q;
    sat_o = 1'b0;
    if (clear) begin
      y_d  = '0;
      xd_d = '0;
    end else if (enable) begin
      xd_d = x_i;
      if (active) begin
        y_d   = s_sat[WIDTH-1:0];
        sat_o = (s_sat != 64'(s));
      end else begin
        y_d = x_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q  <= '0;
      xd_q <= '0;
    end else begin
      y_q  <= y_d;
      xd_q <= xd_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/cascaded_k_high_pass_filter.sv
// Runtime-configurable cascade of k_hpf_stage with shadow config, settle FSM and sticky sat.
// Every cfg_load (or reset) zeroes the pipeline and suppresses y_valid for SETTLE_SAMPLES samples.
module cascaded_k_high_pass_filter
  import cascaded_hpf_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int MAX_ORDER      = 4,
  parameter int KW             = 4,
  parameter int DEFAULT_K      = 6,
  parameter int SETTLE_SAMPLES = 1024
) (
  input logic                          clk,
  input logic                          reset,
  cascaded_k_high_pass_filter_if.slave bus
);
  localparam int OW = $clog2(MAX_ORDER + 1);
  localparam int CW = $clog2(SETTLE_SAMPLES + 1);

  state_e                  state_q, state_d;
  logic [OW-1:0]           order_q, order_d;
  logic [KW-1:0]           k_q, k_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic                    y_valid_q, y_valid_d;
  logic signed [WIDTH-1:0] x0_q, x0_d;

  logic signed [WIDTH-1:0] chain [MAX_ORDER+1];
  logic [MAX_ORDER-1:0]    stage_sat;
  logic                    clear;
  logic                    adv;

  assign clear    = (state_q == CLEAR);
  // A sample coinciding with cfg_load is dropped; the pipeline is about to be zeroed anyway.
  assign adv      = bus.enable && !bus.cfg_load && !clear;
  assign chain[0] = x0_q;

  for (genvar gi = 0; gi < MAX_ORDER; gi++) begin : g_stage
    logic active;
    assign active = (int'(order_q) > gi);
    k_hpf_stage #(
      .WIDTH (WIDTH),
      .KW    (KW)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .active (active),
      .enable (adv),
      .clear  (clear),
      .k      (k_q),
      .x_i    (chain[gi]),
      .y_o    (chain[gi+1]),
      .sat_o  (stage_sat[gi])
    );
  end

  always_comb begin
    state_d   = state_q;
    order_d   = order_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    x0_d      = x0_q;
    y_valid_d = 1'b0;

    case (state_q)
      CLEAR: begin
        cnt_d   = CW'(SETTLE_SAMPLES);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (adv) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        y_valid_d = adv;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    if (clear) begin
      x0_d  = '0;
      sat_d = 1'b0;
    end else if (adv) begin
      x0_d  = bus.x;
      sat_d = sat_q | (|stage_sat);
    end

    if (bus.cfg_load) begin
      order_d = (int'(bus.cfg_order) > MAX_ORDER) ? OW'(MAX_ORDER) : bus.cfg_order;
      k_d     = bus.cfg_k;
      sat_d   = 1'b0;
      state_d = CLEAR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      order_q   <= OW'(MAX_ORDER);
      k_q       <= KW'(DEFAULT_K);
      cnt_q     <= CW'(SETTLE_SAMPLES);
      sat_q     <= 1'b0;
      y_valid_q <= 1'b0;
      x0_q      <= '0;
    end else begin
      state_q   <= state_d;
      order_q   <= order_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      y_valid_q <= y_valid_d;
      x0_q      <= x0_d;
    end
  end

  assign bus.y        = chain[MAX_ORDER];
  assign bus.y_valid  = y_valid_q;
  assign bus.settling = (state_q != RUN);
  assign bus.sat      = sat_q;

endmodule
